ecdsa_sign_ctrl: RTL and testbench
==================================

Name: ecdsa_sign_ctrl

Overview:
Sequencer for ECDSA signature generation, the signing counterpart of the verify path. It computes r = (k·G).x mod n and s = k⁻¹(z + r·d) mod n.
- Owns the FSM, operand/result registers, mod-n reductions and nonce retry logic.
- Hashing, point multiplication, modular inversion and modular multiplication run in external engines driven over start/done handshakes.
- Sits between the top-level ecdsa_sign wrapper and the shared arithmetic units.

Parameters:
W, 256, scalar/coordinate width in bits.
ORDER, P-256 n (FFFFFFFF00000000FFFFFFFFFFFFFFFFBCE6FAADA7179E84F3B9CAC2FC632551), group order n; must satisfy n < 2^W.
MAX_RETRY, 4, number of nonce rejections allowed before sign_error.

Ports:
clk  in  1  clock, all state updates on rising edge.
reset  in  1  asynchronous, active-low; 0 clears all state immediately.
init_sign  in  1  start request; sampled only in IDLE.
priv_key  in  W  private scalar d, latched at init_sign.
start_hash / load_hash  out  1/1  load_hash is a 1-cycle pulse with init_sign; start_hash is a 1-cycle pulse the following cycle.
done_hash  in  1  1-cycle pulse; hash_digest valid in the same cycle.
hash_digest  in  W  leftmost W bits of the message hash.
nonce_req / nonce_valid / nonce  out/in/in  1/1/W  RNG handshake; nonce is sampled when nonce_valid=1.
pm_start / pm_k / pm_done / pm_x  out/out/in/in  1/W/1/W  point multiply k·G; pm_x valid with pm_done.
inv_start / inv_a / inv_done / inv_q  out/out/in/in  1/W/1/W  inv_q = inv_a⁻¹ mod n.
mm_start / mm_a / mm_b / mm_done / mm_p  out/out/out/in/in  1/W/W/1/W  mm_p = mm_a·mm_b mod n.
sig_r, sig_s  out  W/W  signature; valid while done_sign is high.
done_sign  out  1  level; high in DONE state.
sign_error  out  1  level; high in ERROR state.

Behaviour:
Reset:
- All outputs 0, FSM in IDLE, retry counter 0.
- A reset asserted mid-operation aborts immediately. Late engine done pulses arriving after reset are ignored.

Engine handshake rules:
- Every *_start (and nonce_req) is a single-cycle pulse.
- Operand outputs are held stable from the start pulse until the matching done is seen.
- The FSM waits indefinitely for done; there is no timeout.
- A done pulse arriving in any state not waiting for it is ignored.

FSM states and transitions (one cycle per transition excluding engine waits):
- IDLE: on init_sign, latch priv_key, pulse load_hash, then start_hash the next cycle; go to HASH.
- HASH: on done_hash, z = (digest ≥ ORDER) ? digest−ORDER : digest; go to NONCE.
- NONCE: pulse nonce_req and wait for nonce_valid.
  - If nonce==0 or nonce ≥ ORDER: reject via RETRY.
  - Otherwise latch k and go to PMUL.
- PMUL: pm_start with pm_k=k. On pm_done, r = (pm_x ≥ ORDER) ? pm_x−ORDER : pm_x (a single subtract is sufficient because p < 2n).
  - If r==0: RETRY. Otherwise go to INV.
- INV: inv_start with inv_a=k; latch kinv on inv_done; go to MUL1.
- MUL1: mm_start with mm_a=r, mm_b=d; latch rd on mm_done.
- ADD: t = z + rd computed in W+1 bits, then t = (t ≥ ORDER) ? t−ORDER : t. Takes one cycle.
- MUL2: mm_start with mm_a=kinv, mm_b=t; on mm_done, s = mm_p.
  - If s==0: RETRY. Otherwise go to DONE.
- RETRY: retry counter +1.
  - If counter == MAX_RETRY: go to ERROR.
  - Otherwise go to NONCE; z and d are kept.
- DONE: sig_r/sig_s driven, done_sign=1. The next init_sign starts a new signature: outputs clear and the counter zeroes in the same transition as IDLE's.
- ERROR: sign_error=1, sig outputs 0. Cleared by init_sign (restart) or reset.

Busy handling:
- init_sign is ignored in every state except IDLE, DONE and ERROR.
- mm_* is shared by MUL1 and MUL2, which are never concurrent.

Test Plan:
1. Nominal signature: W=8, ORDER=251, bench models engines. d=7, digest=100, nonce=3, pm_x=200 -> r=200, rd=145, t=245, kinv=84, sig_r=200, sig_s=249, done_sign=1. Exactly one pulse each of pm_start, inv_start, and mm_start ×2.
2. Reductions: digest=252, pm_x=253, d=7, nonce=3 -> z=1, r=2, rd=14, t=15, sig_s=84·15 mod 251=5.
3. Nonce rejection: nonce sequence 0, 251, 3 -> two RETRYs, nonce_req pulsed three times, final signature as in scenario 1.
4. r==0 and exhaustion: MAX_RETRY=4, pm_x=251 on every attempt -> four pm_start pulses, then sign_error=1, done_sign=0, sig_r=sig_s=0.
5. Reset mid-operation: assert reset while waiting in INV, then deliver a stray inv_done after release -> all outputs 0, FSM in IDLE, stray done ignored. A following scenario-1 run succeeds.
6. Handshake robustness: init_sign pulsed during MUL1, and engine done latencies varied 1..50 cycles with operands checked stable until done -> extra init_sign ignored, result unchanged, operands held.

Source files
------------

// File: rtl/ecdsa_sign_ctrl_if.sv
// Handshake bundle between the ECDSA signing sequencer, its wrapper and the
// shared hash / RNG / point-multiply / inversion / modular-multiply engines.
interface ecdsa_sign_ctrl_if #(
  parameter int W = 256
);
  logic         init_sign;
  logic [W-1:0] priv_key;
  logic         load_hash;
  logic         start_hash;
  logic         done_hash;
  logic [W-1:0] hash_digest;
  logic         nonce_req;
  logic         nonce_valid;
  logic [W-1:0] nonce;
  logic         pm_start;
  logic [W-1:0] pm_k;
  logic         pm_done;
  logic [W-1:0] pm_x;
  logic         inv_start;
  logic [W-1:0] inv_a;
  logic         inv_done;
  logic [W-1:0] inv_q;
  logic         mm_start;
  logic [W-1:0] mm_a;
  logic [W-1:0] mm_b;
  logic         mm_done;
  logic [W-1:0] mm_p;
  logic [W-1:0] sig_r;
  logic [W-1:0] sig_s;
  logic         done_sign;
  logic         sign_error;

  modport master (
    input  init_sign, priv_key, done_hash, hash_digest, nonce_valid, nonce,
           pm_done, pm_x, inv_done, inv_q, mm_done, mm_p,
    output load_hash, start_hash, nonce_req, pm_start, pm_k, inv_start, inv_a,
           mm_start, mm_a, mm_b, sig_r, sig_s, done_sign, sign_error
  );

  modport slave (
    output init_sign, priv_key, done_hash, hash_digest, nonce_valid, nonce,
           pm_done, pm_x, inv_done, inv_q, mm_done, mm_p,
    input  load_hash, start_hash, nonce_req, pm_start, pm_k, inv_start, inv_a,
           mm_start, mm_a, mm_b, sig_r, sig_s, done_sign, sign_error
  );
endinterface

// File: rtl/ecdsa_sign_ctrl.sv
// ECDSA signing sequencer: r = (k*G).x mod n, s = k^-1 (z + r*d) mod n, with
// external engines on start/done handshakes and bounded nonce retries.
module ecdsa_sign_ctrl #(
  parameter int           W         = 256,
  parameter logic [W-1:0] ORDER     = 256'hFFFFFFFF00000000FFFFFFFFFFFFFFFFBCE6FAADA7179E84F3B9CAC2FC632551,
  parameter int           MAX_RETRY = 4
) (
  input  logic              clk,
  input  logic              reset,
  ecdsa_sign_ctrl_if.master bus
);

  localparam int CW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_HASH, S_NONCE, S_PMUL, S_INV, S_MUL1, S_ADD, S_MUL2, S_RETRY, S_DONE, S_ERROR
  } state_t;

  // Inputs are always < 2n, so one conditional subtract fully reduces them.
  function automatic logic [W-1:0] red_once(input logic [W:0] v);
    logic [W:0] diff;
    diff = v - {1'b0, ORDER};
    return (v >= {1'b0, ORDER}) ? diff[W-1:0] : v[W-1:0];
  endfunction

  state_t        r_state;
  logic [W-1:0]  r_d, r_z, r_k, r_r, r_kinv, r_rd;
  logic [W-1:0]  r_mm_a, r_mm_b, r_sig_r, r_sig_s;
  logic [CW-1:0] r_retry;
  logic          r_hash_pend;
  logic          r_load_hash, r_start_hash, r_nonce_req, r_pm_start, r_inv_start, r_mm_start;
  logic          r_done, r_err;

  logic [W-1:0]  w_z, w_r, w_t;
  logic          w_nonce_bad;
  logic [CW-1:0] w_retry_nxt;

  assign w_z         = red_once({1'b0, bus.hash_digest});
  assign w_r         = red_once({1'b0, bus.pm_x});
  assign w_t         = red_once({1'b0, r_z} + {1'b0, r_rd});
  assign w_nonce_bad = (bus.nonce == '0) || (bus.nonce >= ORDER);
  assign w_retry_nxt = r_retry + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_d          <= '0;
      r_z          <= '0;
      r_k          <= '0;
      r_r          <= '0;
      r_kinv       <= '0;
      r_rd         <= '0;
      r_mm_a       <= '0;
      r_mm_b       <= '0;
      r_sig_r      <= '0;
      r_sig_s      <= '0;
      r_retry      <= '0;
      r_hash_pend  <= 1'b0;
      r_load_hash  <= 1'b0;
      r_start_hash <= 1'b0;
      r_nonce_req  <= 1'b0;
      r_pm_start   <= 1'b0;
      r_inv_start  <= 1'b0;
      r_mm_start   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_load_hash  <= 1'b0;
      r_start_hash <= 1'b0;
      r_nonce_req  <= 1'b0;
      r_pm_start   <= 1'b0;
      r_inv_start  <= 1'b0;
      r_mm_start   <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.init_sign) begin
            r_d         <= bus.priv_key;
            r_retry     <= '0;
            r_k         <= '0;
            r_mm_a      <= '0;
            r_mm_b      <= '0;
            r_sig_r     <= '0;
            r_sig_s     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_load_hash <= 1'b1;
            r_hash_pend <= 1'b1;
            r_state     <= S_HASH;
          end
        end
        S_HASH: begin
          if (r_hash_pend) begin
            r_start_hash <= 1'b1;
            r_hash_pend  <= 1'b0;
          end else if (bus.done_hash) begin
            r_z         <= w_z;
            r_nonce_req <= 1'b1;
            r_state     <= S_NONCE;
          end
        end
        S_NONCE: begin
          if (bus.nonce_valid) begin
            if (w_nonce_bad) begin
              r_state <= S_RETRY;
            end else begin
              r_k        <= bus.nonce;
              r_pm_start <= 1'b1;
              r_state    <= S_PMUL;
            end
          end
        end
        S_PMUL: begin
          if (bus.pm_done) begin
            r_r <= w_r;
            if (w_r == '0) begin
              r_state <= S_RETRY;
            end else begin
              r_inv_start <= 1'b1;
              r_state     <= S_INV;
            end
          end
        end
        S_INV: begin
          if (bus.inv_done) begin
            r_kinv     <= bus.inv_q;
            r_mm_a     <= r_r;
            r_mm_b     <= r_d;
            r_mm_start <= 1'b1;
            r_state    <= S_MUL1;
          end
        end
        S_MUL1: begin
          if (bus.mm_done) begin
            r_rd    <= bus.mm_p;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_mm_a     <= r_kinv;
          r_mm_b     <= w_t;
          r_mm_start <= 1'b1;
          r_state    <= S_MUL2;
        end
        S_MUL2: begin
          if (bus.mm_done) begin
            if (bus.mm_p == '0) begin
              r_state <= S_RETRY;
            end else begin
              r_sig_r <= r_r;
              r_sig_s <= bus.mm_p;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_RETRY: begin
          r_retry <= w_retry_nxt;
          if (w_retry_nxt == CW'(MAX_RETRY)) begin
            r_err   <= 1'b1;
            r_state <= S_ERROR;
          end else begin
            r_nonce_req <= 1'b1;
            r_state     <= S_NONCE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // pm_k and inv_a both carry k; it only changes when a new nonce is accepted.
  assign bus.load_hash  = r_load_hash;
  assign bus.start_hash = r_start_hash;
  assign bus.nonce_req  = r_nonce_req;
  assign bus.pm_start   = r_pm_start;
  assign bus.pm_k       = r_k;
  assign bus.inv_start  = r_inv_start;
  assign bus.inv_a      = r_k;
  assign bus.mm_start   = r_mm_start;
  assign bus.mm_a       = r_mm_a;
  assign bus.mm_b       = r_mm_b;
  assign bus.sig_r      = r_sig_r;
  assign bus.sig_s      = r_sig_s;
  assign bus.done_sign  = r_done;
  assign bus.sign_error = r_err;

endmodule

// File: tb/tb_ecdsa_sign_ctrl.sv
// Bench for ecdsa_sign_ctrl at W=8, n=251: behavioural engines, an
// arithmetic signature model, and a per-cycle output/handshake monitor.
`timescale 1ns/1ps
module tb_ecdsa_sign_ctrl;
  localparam int W    = 8;
  localparam int N    = 251;
  localparam int MAXR = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ecdsa_sign_ctrl_if #(.W(W)) bus ();

  ecdsa_sign_ctrl #(.W(W), .ORDER(8'd251), .MAX_RETRY(MAXR)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scenario configuration
  int cfg_d, cfg_digest;
  int cfg_nonce[8];
  int cfg_pmx[8];
  int lat_lo, lat_hi, inv_lat_fix;

  function automatic int get_nonce(input int i);
    return cfg_nonce[(i < 8) ? i : 7];
  endfunction
  function automatic int get_pmx(input int i);
    return cfg_pmx[(i < 8) ? i : 7];
  endfunction
  function automatic int modinv(input int a);
    for (int x = 1; x < N; x++) if ((a * x) % N == 1) return x;
    return 0;
  endfunction
  function automatic int pick_lat();
    return $urandom_range(lat_hi, lat_lo);
  endfunction

  task automatic set_cfg(input int n0, n1, n2, n3, input int p0, p1, p2, p3);
    cfg_nonce[0] = n0; cfg_nonce[1] = n1; cfg_nonce[2] = n2;
    for (int i = 3; i < 8; i++) cfg_nonce[i] = n3;
    cfg_pmx[0] = p0; cfg_pmx[1] = p1; cfg_pmx[2] = p2;
    for (int i = 3; i < 8; i++) cfg_pmx[i] = p3;
  endtask

  // Signature model straight from the algorithm: attempts consume nonces and
  // point-multiply results in order until success or MAXR rejections.
  task automatic model_run(output logic ok, output int er, output int es,
                           output int nreq, output int npm, output int ninv, output int nmm);
    int z, k, r, s, retries, ni, pi;
    z = cfg_digest % N;
    retries = 0; ni = 0; pi = 0;
    ok = 1'b0; er = 0; es = 0; nreq = 0; npm = 0; ninv = 0; nmm = 0;
    forever begin
      k = get_nonce(ni); ni++; nreq++;
      if (k != 0 && k < N) begin
        npm++;
        r = get_pmx(pi) % N; pi++;
        if (r != 0) begin
          ninv++; nmm += 2;
          s = (modinv(k) * ((z + r * cfg_d) % N)) % N;
          if (s != 0) begin
            ok = 1'b1; er = r; es = s;
            return;
          end
        end
      end
      retries++;
      if (retries == MAXR) return;
    end
  endtask

  // Behavioural engines, driven on the falling edge
  int h_cnt = 0, q_cnt = 0, p_cnt = 0, i_cnt = 0, m_cnt = 0;
  int p_cap = 0, i_cap = 0, ma_cap = 0, mb_cap = 0;
  int nonce_idx = 0, pmx_idx = 0;

  initial begin : engines
    bus.done_hash = 1'b0; bus.nonce_valid = 1'b0; bus.pm_done = 1'b0;
    bus.inv_done = 1'b0; bus.mm_done = 1'b0;
    bus.hash_digest = '0; bus.nonce = '0; bus.pm_x = '0; bus.inv_q = '0; bus.mm_p = '0;
    forever begin
      @(negedge clk);
      bus.done_hash = 1'b0; bus.nonce_valid = 1'b0; bus.pm_done = 1'b0;
      bus.inv_done = 1'b0; bus.mm_done = 1'b0;
      if (bus.load_hash) begin nonce_idx = 0; pmx_idx = 0; end
      if (h_cnt > 0) begin
        h_cnt--;
        if (h_cnt == 0) begin bus.done_hash = 1'b1; bus.hash_digest = W'(cfg_digest); end
      end
      if (q_cnt > 0) begin
        q_cnt--;
        if (q_cnt == 0) begin bus.nonce_valid = 1'b1; bus.nonce = W'(get_nonce(nonce_idx)); nonce_idx++; end
      end
      if (p_cnt > 0) begin
        p_cnt--;
        if (p_cnt == 0) begin bus.pm_done = 1'b1; bus.pm_x = W'(get_pmx(pmx_idx)); pmx_idx++; end
      end
      if (i_cnt > 0) begin
        i_cnt--;
        if (i_cnt == 0) begin bus.inv_done = 1'b1; bus.inv_q = W'(modinv(i_cap)); end
      end
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin bus.mm_done = 1'b1; bus.mm_p = W'((ma_cap * mb_cap) % N); end
      end
      if (bus.start_hash) h_cnt = pick_lat();
      if (bus.nonce_req)  q_cnt = pick_lat();
      if (bus.pm_start)  begin p_cnt = pick_lat(); p_cap = int'(bus.pm_k); end
      if (bus.inv_start) begin i_cnt = (inv_lat_fix > 0) ? inv_lat_fix : pick_lat(); i_cap = int'(bus.inv_a); end
      if (bus.mm_start)  begin m_cnt = pick_lat(); ma_cap = int'(bus.mm_a); mb_cap = int'(bus.mm_b); end
    end
  end

  // Per-cycle monitor
  logic mon_en = 1'b0;
  logic exp_ok = 1'b0;
  int   exp_r = 0, exp_s = 0;
  int   n_load = 0, n_nreq = 0, n_pm = 0, n_inv = 0, n_mm = 0;

  function automatic longint out_vec();
    return {bus.load_hash, bus.start_hash, bus.nonce_req, bus.pm_start, bus.inv_start, bus.mm_start,
            bus.pm_k, bus.inv_a, bus.mm_a, bus.mm_b, bus.sig_r, bus.sig_s, bus.done_sign, bus.sign_error};
  endfunction

  initial begin : compare
    logic [5:0] prev, cur;
    prev = '0;
    forever begin
      @(posedge clk); #1;
      cur = {bus.load_hash, bus.start_hash, bus.nonce_req, bus.pm_start, bus.inv_start, bus.mm_start};
      n_load += int'(cur[5]); n_nreq += int'(cur[3]); n_pm += int'(cur[2]);
      n_inv  += int'(cur[1]); n_mm   += int'(cur[0]);
      if (mon_en) begin
        if (cur != '0) check("pulse_width", longint'(cur & prev), 0);
        if (p_cnt > 0) check("pm_k_stable", bus.pm_k, p_cap);
        if (i_cnt > 0) check("inv_a_stable", bus.inv_a, i_cap);
        if (m_cnt > 0) begin
          check("mm_a_stable", bus.mm_a, ma_cap);
          check("mm_b_stable", bus.mm_b, mb_cap);
        end
        if (bus.done_sign) begin
          check("done_vs_model", exp_ok, 1);
          check("err_with_done", bus.sign_error, 0);
          check("sig_r_model", bus.sig_r, exp_r);
          check("sig_s_model", bus.sig_s, exp_s);
        end else if (bus.sign_error) begin
          check("error_vs_model", exp_ok, 0);
          check("sig_r_err_zero", bus.sig_r, 0);
          check("sig_s_err_zero", bus.sig_s, 0);
        end else begin
          check("sig_r_busy_zero", bus.sig_r, 0);
          check("sig_s_busy_zero", bus.sig_s, 0);
        end
      end
      prev = cur;
    end
  end

  task automatic run_sig(input string tag, input int d, input int digest, input int lo, input int hi,
                         input bit inject, input bit lit_ok, input int lit_r, input int lit_s, input int lit_pm);
    logic ok;
    int er, es, e_nreq, e_pm, e_inv, e_mm, cyc;
    int b_load, b_nreq, b_pm, b_inv, b_mm;
    cfg_d = d; cfg_digest = digest; lat_lo = lo; lat_hi = hi;
    model_run(ok, er, es, e_nreq, e_pm, e_inv, e_mm);
    check({tag, "_model_pin"}, {ok, 8'(er), 8'(es), 8'(e_pm)}, {lit_ok, 8'(lit_r), 8'(lit_s), 8'(lit_pm)});
    @(negedge clk);
    exp_ok = ok; exp_r = er; exp_s = es;
    b_load = n_load; b_nreq = n_nreq; b_pm = n_pm; b_inv = n_inv; b_mm = n_mm;
    bus.priv_key = W'(d); bus.init_sign = 1'b1;
    @(posedge clk); #1;
    check({tag, "_load_hash"}, {bus.load_hash, bus.start_hash}, 2);
    @(negedge clk);
    bus.init_sign = 1'b0; bus.priv_key = '0;
    @(posedge clk); #1;
    check({tag, "_start_hash"}, {bus.load_hash, bus.start_hash}, 1);
    if (inject) begin
      cyc = 0;
      while (!bus.mm_start && cyc < 3000) begin @(posedge clk); #1; cyc++; end
      check({tag, "_mul1_reached"}, longint'(cyc < 3000), 1);
      @(negedge clk); bus.priv_key = 8'd99; bus.init_sign = 1'b1;
      @(negedge clk); bus.init_sign = 1'b0; bus.priv_key = '0;
    end
    cyc = 0;
    while (!(bus.done_sign || bus.sign_error) && cyc < 5000) begin @(posedge clk); #1; cyc++; end
    check({tag, "_finish_in_time"}, longint'(cyc < 5000), 1);
    check({tag, "_done_sign"}, bus.done_sign, lit_ok);
    check({tag, "_sign_error"}, bus.sign_error, !lit_ok);
    check({tag, "_sig_r"}, bus.sig_r, lit_r);
    check({tag, "_sig_s"}, bus.sig_s, lit_s);
    check({tag, "_n_load_hash"}, n_load - b_load, 1);
    check({tag, "_n_nonce_req"}, n_nreq - b_nreq, e_nreq);
    check({tag, "_n_pm_start"}, n_pm - b_pm, e_pm);
    check({tag, "_n_inv_start"}, n_inv - b_inv, e_inv);
    check({tag, "_n_mm_start"}, n_mm - b_mm, e_mm);
  endtask

  initial begin : main
    int cyc;
    reset = 1'b0; bus.init_sign = 1'b0; bus.priv_key = '0;
    inv_lat_fix = 0; lat_lo = 1; lat_hi = 1; cfg_d = 0; cfg_digest = 0;
    set_cfg(3, 3, 3, 3, 200, 200, 200, 200);
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 0);
    reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    set_cfg(3, 3, 3, 3, 200, 200, 200, 200);
    run_sig("s1_nominal", 7, 100, 1, 3, 1'b0, 1'b1, 200, 249, 1);
    set_cfg(3, 3, 3, 3, 253, 253, 253, 253);
    run_sig("s2_reduce", 7, 252, 2, 4, 1'b0, 1'b1, 2, 5, 1);
    set_cfg(0, 251, 3, 3, 200, 200, 200, 200);
    run_sig("s3_nonce_rej", 7, 100, 1, 2, 1'b0, 1'b1, 200, 249, 1);
    set_cfg(3, 3, 3, 3, 251, 251, 251, 251);
    run_sig("s4_exhaust", 7, 100, 1, 3, 1'b0, 1'b0, 0, 0, 4);

    // Abort while waiting on inversion, then let the late inv_done land in IDLE
    set_cfg(3, 3, 3, 3, 200, 200, 200, 200);
    cfg_d = 7; cfg_digest = 100; lat_lo = 1; lat_hi = 1; inv_lat_fix = 12;
    @(negedge clk); bus.priv_key = 8'd7; bus.init_sign = 1'b1;
    @(negedge clk); bus.init_sign = 1'b0; bus.priv_key = '0;
    cyc = 0;
    while (!bus.inv_start && cyc < 500) begin @(posedge clk); #1; cyc++; end
    check("s5_inv_reached", longint'(cyc < 500), 1);
    mon_en = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0; #1;
    check("s5_async_clear", out_vec(), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    while (i_cnt > 0 && cyc < 100) begin @(negedge clk); cyc++; end
    check("s5_stray_after_release", longint'(cyc > 0 && cyc < 100), 1);
    repeat (5) @(negedge clk);
    check("s5_idle_after_stray", out_vec(), 0);
    inv_lat_fix = 0;
    mon_en = 1'b1;
    run_sig("s5_rerun", 7, 100, 1, 2, 1'b0, 1'b1, 200, 249, 1);

    set_cfg(3, 3, 3, 3, 200, 200, 200, 200);
    run_sig("s6_robust", 7, 100, 1, 50, 1'b1, 1'b1, 200, 249, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
